// File: rtl/pspin_cmd_arbiter.sv
// Round-robin command arbiter from HPU clusters onto shared command interfaces,
// with per-interface credit limiting and combinational completion routing.
package pspin_cmd_pkg;
    localparam int unsigned NUM_CLUSTERS       = 4;
    localparam int unsigned NUM_CMD_INTERFACES = 3;

    typedef struct packed {
        logic [2:0] cluster_id;
        logic [4:0] local_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
        logic [1:0]    intf_id;
        logic [31:0]   data;
    } pspin_cmd_req_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
        logic [7:0]    status;
    } pspin_cmd_resp_t;
endpackage

module pspin_cmd_arbiter
    import pspin_cmd_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = NUM_CLUSTERS,
    parameter  int unsigned NUM_INTF     = NUM_CMD_INTERFACES,
    parameter  int unsigned MAX_INFLIGHT = 16,
    localparam int unsigned CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic            [NUM_REQ-1:0]       req_valid_i,
    output logic            [NUM_REQ-1:0]       req_ready_o,
    input  pspin_cmd_req_t  [NUM_REQ-1:0]       req_i,
    output logic            [NUM_INTF-1:0]      intf_valid_o,
    input  logic            [NUM_INTF-1:0]      intf_ready_i,
    output pspin_cmd_req_t                      intf_req_o,
    input  logic            [NUM_INTF-1:0]      intf_resp_valid_i,
    output logic            [NUM_INTF-1:0]      intf_resp_ready_o,
    input  pspin_cmd_resp_t [NUM_INTF-1:0]      intf_resp_i,
    output logic            [NUM_REQ-1:0]       resp_valid_o,
    output pspin_cmd_resp_t [NUM_REQ-1:0]       resp_o,
    output logic            [NUM_INTF-1:0][CW-1:0] inflight_o,
    output logic                                err_o
);

    localparam int unsigned RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ST_EMPTY, ST_FULL} stage_e;

    stage_e                        r_state, w_state_nxt;
    pspin_cmd_req_t                r_req;
    logic [RW-1:0]                 r_rr;
    logic [NUM_INTF-1:0][CW-1:0]   r_inflight;
    logic                          r_err;

    logic [NUM_INTF-1:0]           w_intf_valid;
    logic                          w_drain;
    logic                          w_can_load;
    logic [NUM_INTF-1:0]           w_room;
    logic [NUM_REQ-1:0]            w_elig;
    logic [NUM_REQ-1:0]            w_inval;
    logic                          w_gnt_vld;
    logic [RW-1:0]                 w_gnt_idx;
    logic                          w_inv_vld;
    logic [RW-1:0]                 w_inv_idx;
    logic                          w_inv_acc;
    int unsigned                   w_scan;
    logic [RW-1:0]                 w_pos;
    logic [NUM_INTF-1:0]           w_resp_ready;
    logic [NUM_REQ-1:0]            w_resp_valid;
    pspin_cmd_resp_t [NUM_REQ-1:0] w_resp;
    logic                          w_bad_cid;
    logic [NUM_INTF-1:0]           w_issue;
    logic [NUM_INTF-1:0]           w_ret;
    logic                          w_uflow;

    always_comb begin
        w_intf_valid = '0;
        w_drain      = 1'b0;
        for (int unsigned k = 0; k < NUM_INTF; k++) begin
            if (r_state == ST_FULL && 32'(r_req.intf_id) == k) begin
                w_intf_valid[k] = 1'b1;
                w_drain         = intf_ready_i[k] & rst_ni;
            end
        end
    end

    assign w_can_load = rst_ni && (r_state == ST_EMPTY || w_drain);

    // The entry sitting in the stage already owns a credit on its interface.
    always_comb begin
        w_room = '0;
        for (int unsigned k = 0; k < NUM_INTF; k++) begin
            w_room[k] = (32'(r_inflight[k]) + 32'(w_intf_valid[k])) < MAX_INFLIGHT;
        end
    end

    always_comb begin
        w_elig  = '0;
        w_inval = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i]) begin
                if (32'(req_i[i].intf_id) >= NUM_INTF) begin
                    w_inval[i] = 1'b1;
                end else begin
                    for (int unsigned k = 0; k < NUM_INTF; k++) begin
                        if (32'(req_i[i].intf_id) == k && w_room[k]) w_elig[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_scan    = 0;
        w_pos     = '0;
        for (int unsigned o = 0; o < NUM_REQ; o++) begin
            w_scan = (32'(r_rr) + o) % NUM_REQ;
            w_pos  = w_scan[RW-1:0];
            if (w_can_load && !w_gnt_vld && w_elig[w_pos]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_pos;
            end
        end
    end

    // Invalid-interface requests are only swallowed when nobody useful is waiting.
    always_comb begin
        w_inv_vld = 1'b0;
        w_inv_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_inv_vld && w_inval[i]) begin
                w_inv_vld = 1'b1;
                w_inv_idx = RW'(i);
            end
        end
        w_inv_acc = rst_ni && w_inv_vld && !(|w_elig);
    end

    always_comb begin
        req_ready_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = (w_gnt_vld && w_gnt_idx == RW'(i)) ||
                             (w_inv_acc && w_inv_idx == RW'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_gnt_vld)    w_state_nxt = ST_FULL;
        else if (w_drain) w_state_nxt = ST_EMPTY;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
            r_req   <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt_vld) begin
                r_req <= req_i[w_gnt_idx];
                r_rr  <= RW'((32'(w_gnt_idx) + 1) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_resp_ready = '0;
        w_resp_valid = '0;
        w_resp       = '0;
        w_bad_cid    = 1'b0;
        for (int unsigned k = 0; k < NUM_INTF; k++) begin
            if (intf_resp_valid_i[k] && 32'(intf_resp_i[k].cmd_id.cluster_id) >= NUM_REQ) begin
                w_resp_ready[k] = 1'b1;
                w_bad_cid       = 1'b1;
            end
        end
        for (int unsigned c = 0; c < NUM_REQ; c++) begin
            for (int unsigned k = 0; k < NUM_INTF; k++) begin
                if (!w_resp_valid[c] && intf_resp_valid_i[k] &&
                    32'(intf_resp_i[k].cmd_id.cluster_id) == c) begin
                    w_resp_valid[c] = 1'b1;
                    w_resp[c]       = intf_resp_i[k];
                    w_resp_ready[k] = 1'b1;
                end
            end
        end
        if (!rst_ni) begin
            w_resp_ready = '0;
            w_resp_valid = '0;
            w_resp       = '0;
            w_bad_cid    = 1'b0;
        end
    end

    always_comb begin
        w_issue = '0;
        w_ret   = '0;
        w_uflow = 1'b0;
        for (int unsigned k = 0; k < NUM_INTF; k++) begin
            w_issue[k] = w_drain && w_intf_valid[k];
            w_ret[k]   = intf_resp_valid_i[k] && w_resp_ready[k];
            if (w_ret[k] && !w_issue[k] && r_inflight[k] == '0) w_uflow = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_INTF; k++) begin
                if (w_issue[k] && !w_ret[k]) begin
                    r_inflight[k] <= r_inflight[k] + CW'(1);
                end else if (w_ret[k] && !w_issue[k] && r_inflight[k] != '0) begin
                    r_inflight[k] <= r_inflight[k] - CW'(1);
                end
            end
            r_err <= w_inv_acc | w_bad_cid | w_uflow;
        end
    end

    assign intf_valid_o      = w_intf_valid;
    assign intf_req_o        = r_req;
    assign intf_resp_ready_o = w_resp_ready;
    assign resp_valid_o      = w_resp_valid;
    assign resp_o            = w_resp;
    assign inflight_o        = r_inflight;
    assign err_o             = r_err;

endmodule

// File: tb/tb_pspin_cmd_arbiter.sv
// Directed bench for pspin_cmd_arbiter: a cycle model checked every negedge,
// plus hand-computed literal expectations for each scenario.
module tb_pspin_cmd_arbiter;
    import pspin_cmd_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0]             req_valid, req_ready;
    pspin_cmd_req_t  [3:0]  req;
    logic [2:0]             intf_valid, intf_ready;
    pspin_cmd_req_t         intf_req;
    logic [2:0]             rv, rr;
    pspin_cmd_resp_t [2:0]  iresp;
    logic [3:0]             resp_valid;
    pspin_cmd_resp_t [3:0]  resp;
    logic [2:0][4:0]        inflight;
    logic                   err;

    int errors = 0;
    int checks = 0;

    pspin_cmd_arbiter #(.NUM_REQ(4), .NUM_INTF(3), .MAX_INFLIGHT(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req),
        .intf_valid_o(intf_valid), .intf_ready_i(intf_ready), .intf_req_o(intf_req),
        .intf_resp_valid_i(rv), .intf_resp_ready_o(rr), .intf_resp_i(iresp),
        .resp_valid_o(resp_valid), .resp_o(resp),
        .inflight_o(inflight), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic pspin_cmd_req_t mk_req(int cid, int iid, logic [31:0] d);
        pspin_cmd_req_t r;
        r = '0;
        r.cmd_id.cluster_id = 3'(cid);
        r.cmd_id.local_id   = 5'(cid + 1);
        r.intf_id           = 2'(iid);
        r.data              = d;
        return r;
    endfunction

    function automatic pspin_cmd_resp_t mk_resp(int cid, logic [7:0] st);
        pspin_cmd_resp_t r;
        r = '0;
        r.cmd_id.cluster_id = 3'(cid);
        r.status            = st;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    bit             m_full;
    pspin_cmd_req_t m_stage;
    int             m_rr;
    int             m_infl [3];
    bit             m_err;

    logic [3:0]      e_req_ready;
    logic [2:0]      e_intf_valid;
    logic [3:0]      e_resp_valid;
    pspin_cmd_resp_t e_resp [4];
    logic [2:0]      e_resp_ready;
    bit              e_err_next;
    int              e_gnt;
    bit              e_drain;

    function automatic void model_eval();
        bit elig [4];
        int inv;
        bit any;
        int k, i, used, cid;
        e_req_ready = '0; e_intf_valid = '0; e_resp_valid = '0; e_resp_ready = '0;
        for (int c = 0; c < 4; c++) e_resp[c] = '0;
        e_err_next = 0; e_gnt = -1; e_drain = 0;
        inv = -1; any = 0;
        for (int n = 0; n < 4; n++) elig[n] = 0;
        if (rst_n !== 1'b1) return;
        if (m_full) begin
            e_intf_valid[m_stage.intf_id] = 1'b1;
            e_drain = intf_ready[m_stage.intf_id];
        end
        for (i = 0; i < 4; i++) begin
            if (req_valid[i]) begin
                if (req[i].intf_id >= 3) begin
                    if (inv < 0) inv = i;
                end else begin
                    k = req[i].intf_id;
                    used = m_infl[k] + ((m_full && m_stage.intf_id == k) ? 1 : 0);
                    if (used < 16) begin elig[i] = 1; any = 1; end
                end
            end
        end
        if (!m_full || e_drain)
            for (int n = 0; n < 4; n++) begin
                i = (m_rr + n) % 4;
                if (e_gnt < 0 && elig[i]) e_gnt = i;
            end
        if (e_gnt >= 0) e_req_ready[e_gnt] = 1'b1;
        if (!any && inv >= 0) begin e_req_ready[inv] = 1'b1; e_err_next = 1; end
        for (k = 0; k < 3; k++)
            if (rv[k] && iresp[k].cmd_id.cluster_id >= 4) begin
                e_resp_ready[k] = 1'b1; e_err_next = 1;
            end
        for (int c = 0; c < 4; c++)
            for (k = 0; k < 3; k++) begin
                cid = iresp[k].cmd_id.cluster_id;
                if (!e_resp_valid[c] && rv[k] && cid == c) begin
                    e_resp_valid[c] = 1'b1; e_resp[c] = iresp[k]; e_resp_ready[k] = 1'b1;
                end
            end
        for (k = 0; k < 3; k++)
            if (e_resp_ready[k] && !(e_drain && m_stage.intf_id == k) && m_infl[k] == 0)
                e_err_next = 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 0; m_stage <= '0; m_rr <= 0; m_err <= 0;
            for (int k = 0; k < 3; k++) m_infl[k] <= 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if ((e_drain && m_stage.intf_id == k) && !e_resp_ready[k]) m_infl[k] <= m_infl[k] + 1;
                else if (e_resp_ready[k] && !(e_drain && m_stage.intf_id == k) && m_infl[k] > 0)
                    m_infl[k] <= m_infl[k] - 1;
            end
            if (e_gnt >= 0) begin
                m_full <= 1; m_stage <= req[e_gnt]; m_rr <= (e_gnt + 1) % 4;
            end else if (e_drain) m_full <= 0;
            m_err <= e_err_next;
        end
    end

    always @(negedge clk) begin
        model_eval();
        chk("req_ready", 64'(req_ready), 64'(e_req_ready));
        chk("intf_valid", 64'(intf_valid), 64'(e_intf_valid));
        if (m_full) chk("intf_req", 64'(intf_req), 64'(m_stage));
        chk("resp_valid", 64'(resp_valid), 64'(e_resp_valid));
        for (int c = 0; c < 4; c++) if (e_resp_valid[c]) chk("resp", 64'(resp[c]), 64'(e_resp[c]));
        chk("resp_ready", 64'(rr), 64'(e_resp_ready));
        for (int k = 0; k < 3; k++) chk("inflight", 64'(inflight[k]), 64'(m_infl[k]));
        chk("err", 64'(err), 64'(m_err));
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); #1; endtask
    task automatic clear_in();
        req_valid = '0; rv = '0;
        for (int i = 0; i < 4; i++) req[i] = '0;
        for (int k = 0; k < 3; k++) iresp[k] = '0;
    endtask
    task automatic do_reset();
        nxt(); clear_in(); rst_n = 1'b0;
        nxt(); rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clear_in(); intf_ready = 3'b111;
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_intf_valid", 64'(intf_valid), 64'h0);
        chk("rst_inflight", 64'(inflight), 64'h0);
        chk("rst_intf_req", 64'(intf_req), 64'h0);
        nxt(); rst_n = 1'b1; clear_in();

        // single command
        req[2] = mk_req(2, 1, 32'hCAFE0002); req_valid = 4'b0100;
        mid(); chk("single_gnt", 64'(req_ready), 64'h4);
        nxt(); req_valid = 0;
        mid(); chk("single_valid", 64'(intf_valid), 64'h2);
        chk("single_data", 64'(intf_req.data), 64'hCAFE0002);
        nxt(); mid(); chk("single_infl", 64'(inflight[1]), 64'h1);
        nxt(); rv = 3'b010; iresp[1] = mk_resp(2, 8'h5A);
        mid(); chk("single_resp_v", 64'(resp_valid), 64'h4);
        chk("single_resp_st", 64'(resp[2].status), 64'h5A);
        nxt(); rv = 0;
        mid(); chk("single_infl0", 64'(inflight[1]), 64'h0);
        chk("single_err", 64'(err), 64'h0);

        // round robin
        do_reset();
        for (int i = 0; i < 4; i++) req[i] = mk_req(i, 0, 32'(i));
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            mid();
            chk("rr_gnt", 64'(req_ready), 64'(1 << (n % 4)));
            if (n > 0) begin
                chk("rr_valid", 64'(intf_valid), 64'h1);
                chk("rr_data", 64'(intf_req.data), 64'((n - 1) % 4));
            end
            nxt();
        end

        // credit limit
        do_reset();
        req[0] = mk_req(0, 2, 32'h100); req_valid = 4'b0001;
        for (int n = 0; n < 18; n++) begin
            mid();
            chk("cred_gnt", 64'(req_ready), (n < 16) ? 64'h1 : 64'h0);
            if (n == 17) chk("cred_infl16", 64'(inflight[2]), 64'd16);
            nxt();
        end
        rv = 3'b100; iresp[2] = mk_resp(0, 8'h01);
        mid(); chk("cred_stall", 64'(req_ready), 64'h0);
        chk("cred_resp", 64'(resp_valid), 64'h1);
        nxt(); rv = 0;
        mid(); chk("cred_17th", 64'(req_ready), 64'h1);
        chk("cred_infl15", 64'(inflight[2]), 64'd15);
        nxt(); req_valid = 0; rv = 3'b100;
        mid(); chk("cred_stage", 64'(intf_valid), 64'h4);
        nxt(); rv = 0;
        mid(); chk("cred_same", 64'(inflight[2]), 64'd15);
        chk("cred_empty", 64'(intf_valid), 64'h0);

        // backpressure
        do_reset();
        intf_ready = 3'b000;
        req[1] = mk_req(1, 0, 32'hB1); req[3] = mk_req(3, 0, 32'hB3);
        req_valid = 4'b1010;
        mid(); chk("bp_gnt", 64'(req_ready), 64'h2);
        nxt(); req_valid = 4'b1000;
        for (int n = 0; n < 5; n++) begin
            mid();
            chk("bp_noready", 64'(req_ready), 64'h0);
            chk("bp_hold", 64'(intf_req.data), 64'hB1);
            nxt();
        end
        intf_ready = 3'b111;
        mid(); chk("bp_refill", 64'(req_ready), 64'h8);
        chk("bp_valid", 64'(intf_valid), 64'h1);
        nxt(); req_valid = 0;
        mid(); chk("bp_next", 64'(intf_req.data), 64'hB3);
        nxt(); mid(); chk("bp_drained", 64'(intf_valid), 64'h0);

        // response collision
        nxt(); rv = 3'b101; iresp[0] = mk_resp(1, 8'hA0); iresp[2] = mk_resp(1, 8'hA2);
        mid(); chk("col_ready0", 64'(rr), 64'h1);
        chk("col_valid", 64'(resp_valid), 64'h2);
        chk("col_st0", 64'(resp[1].status), 64'hA0);
        nxt(); rv = 3'b100;
        mid(); chk("col_ready2", 64'(rr), 64'h4);
        chk("col_st2", 64'(resp[1].status), 64'hA2);
        nxt(); rv = 0;
        mid(); chk("col_uflow_err", 64'(err), 64'h1);

        // errors
        do_reset();
        req[0] = mk_req(0, 3, 32'hEE); req_valid = 4'b0001;
        mid(); chk("inv_acc", 64'(req_ready), 64'h1);
        chk("inv_err_pre", 64'(err), 64'h0);
        nxt(); req_valid = 0;
        mid(); chk("inv_novalid", 64'(intf_valid), 64'h0);
        chk("inv_err", 64'(err), 64'h1);
        nxt(); mid(); chk("inv_err_once", 64'(err), 64'h0);
        nxt(); req[1] = mk_req(1, 0, 32'h11); req_valid = 4'b0011;
        mid(); chk("inv_yield", 64'(req_ready), 64'h2);
        nxt(); req_valid = 4'b0001;
        mid(); chk("inv_alone", 64'(req_ready), 64'h1);
        nxt(); req_valid = 0; rv = 3'b010; iresp[1] = mk_resp(0, 8'h77);
        mid(); chk("uf_routed", 64'(resp_valid), 64'h1);
        nxt(); rv = 0;
        mid(); chk("uf_err", 64'(err), 64'h1);
        chk("uf_infl", 64'(inflight[1]), 64'h0);
        nxt(); rv = 3'b001; iresp[0] = mk_resp(6, 8'h66);
        mid(); chk("badcid_ready", 64'(rr), 64'h1);
        chk("badcid_nov", 64'(resp_valid), 64'h0);
        nxt(); rv = 0;
        mid(); chk("badcid_err", 64'(err), 64'h1);

        // reset mid-transfer
        nxt(); intf_ready = 3'b000; req[2] = mk_req(2, 1, 32'h22); req_valid = 4'b0100;
        nxt(); req_valid = 0;
        mid(); chk("mr_full", 64'(intf_valid), 64'h2);
        nxt(); #1; rst_n = 1'b0; req_valid = 4'b0100; #1;
        chk("mr_valid", 64'(intf_valid), 64'h0);
        chk("mr_ready", 64'(req_ready), 64'h0);
        chk("mr_infl", 64'(inflight), 64'h0);
        chk("mr_req", 64'(intf_req), 64'h0);
        mid(); nxt(); rst_n = 1'b1; req_valid = 0;
        mid(); nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
